fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_ctrl.sv | 85 ++++++++
 tb/tb_fetch_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: redirect/flush, instruction-queue enqueue and I-cache read request/response.
// The master modport is the fetch controller; the slave is the surrounding pipeline/cache.
interface fetch_ctrl_if;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        iq_full;
    logic        icache_read;
    logic [31:0] icache_addr;
    logic        icache_resp;
    logic [31:0] icache_rdata;
    logic        iq_enq;
    logic [31:0] iq_pc;
    logic [31:0] iq_instr;

    modport master (
        input  flush_valid, flush_pc, iq_full, icache_resp, icache_rdata,
        output icache_read, icache_addr, iq_enq, iq_pc, iq_instr
    );

    modport slave (
        output flush_valid, flush_pc, iq_full, icache_resp, icache_rdata,
        input  icache_read, icache_addr, iq_enq, iq_pc, iq_instr
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetcher; read issues the cycle after an IDLE with room, enqueue is combinational with icache_resp.
// Backpressure: iq_full is sampled only in IDLE; a flush during a read parks in DRAIN until the stale response returns.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  fb
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] flush_pc_aligned;
    logic        enq;

    assign flush_pc_aligned = fb.flush_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        enq        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fb.flush_valid) begin
                    pc_d = flush_pc_aligned;
                end else if (!fb.iq_full) begin
                    req_addr_d = pc_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fb.icache_resp) begin
                    state_d = ST_IDLE;
                    if (fb.flush_valid) begin
                        pc_d = flush_pc_aligned;
                    end else begin
                        enq  = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (fb.flush_valid) begin
                    // The read stays on the bus; its response must be swallowed.
                    pc_d    = flush_pc_aligned;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fb.flush_valid) begin
                    pc_d = flush_pc_aligned;
                end
                if (fb.icache_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            req_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Reset masks the strobes in the cycle it is asserted so nothing leaks while the cache is also resetting.
    assign fb.icache_read = (state_q == ST_WAIT || state_q == ST_DRAIN) && !rst;
    assign fb.icache_addr = req_addr_q;
    assign fb.iq_enq      = enq && !rst;
    assign fb.iq_pc       = req_addr_q;
    assign fb.iq_instr    = fb.icache_rdata;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h00000060;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .fb  (bus)
    );

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] fpc;
        logic        full;
        logic        resp;
        logic [31:0] rdata;
        logic        chk;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_enq;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fv, input logic [31:0] fpc,
                         input logic full, input logic resp, input logic [31:0] rd);
        @(negedge clk);
        rst              = r;
        bus.flush_valid  = fv;
        bus.flush_pc     = fpc;
        bus.iq_full      = full;
        bus.icache_resp  = resp;
        bus.icache_rdata = rd;
        #1;
    endtask

    task automatic v(input logic r, input logic fv, input logic [31:0] fpc, input logic full,
                     input logic resp, input logic [31:0] rd, input logic chk, input logic e_read,
                     input logic [31:0] e_addr, input logic e_enq, input logic [31:0] e_pc,
                     input logic [31:0] e_instr);
        vec_t t;
        t.rst = r; t.fv = fv; t.fpc = fpc; t.full = full; t.resp = resp; t.rdata = rd;
        t.chk = chk; t.e_read = e_read; t.e_addr = e_addr; t.e_enq = e_enq;
        t.e_pc = e_pc; t.e_instr = e_instr;
        tbl.push_back(t);
    endtask

    // Reference model: next fetch PC, one outstanding read, and whether its data is stale.
    logic        m_busy, m_kill;
    logic [31:0] m_pc, m_addr;

    initial begin
        logic        r, fv, full, resp;
        logic [31:0] fpc, rd;
        logic        x_read, x_enq;

        rst = 1'b1;
        bus.flush_valid = 1'b0; bus.flush_pc = 32'h0; bus.iq_full = 1'b0;
        bus.icache_resp = 1'b0; bus.icache_rdata = 32'h0;

        //  rst fv fpc           full resp rdata         chk rd addr          enq pc            instr
        v(1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0);
        v(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h60,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h60,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'h13,       1, 1, 32'h60,       1, 32'h60,       32'h13);
        for (int k = 0; k < 5; k++)
            v(0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h64,       0, 32'h0,        32'h0);
        v(0, 1, 32'h1002,     0, 0, 32'h0,        1, 1, 32'h64,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h64,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h64,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 1, 1, 32'h64,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h1000,     0, 32'h0,        32'h0);
        v(0, 1, 32'h200,      0, 1, 32'hCAFE0001, 1, 1, 32'h1000,     0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0,        32'h0);
        v(0, 1, 32'h300,      0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0,        32'h0);
        v(0, 1, 32'h400,      0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'hCAFE0002, 1, 1, 32'h200,      0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h400,      0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'h11,       1, 1, 32'h400,      1, 32'h400,      32'h11);
        v(0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'h22,       1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h22);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'h33,       1, 1, 32'h0,        1, 32'h0,        32'h33);
        v(0, 0, 32'h0,        1, 1, 32'h34,       1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h4,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        1, 1, 32'h44,       1, 1, 32'h4,        1, 32'h4,        32'h44);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,        32'h0);
        v(1, 0, 32'h0,        0, 1, 32'h66,       1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h60,       0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 1, 32'h55,       1, 1, 32'h60,       1, 32'h60,       32'h55);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h64,       0, 32'h0,        32'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fv, tbl[i].fpc, tbl[i].full, tbl[i].resp, tbl[i].rdata);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d.icache_read", i), {31'b0, bus.icache_read}, {31'b0, tbl[i].e_read});
                check($sformatf("vec%0d.iq_enq", i), {31'b0, bus.iq_enq}, {31'b0, tbl[i].e_enq});
                if (tbl[i].e_read)
                    check($sformatf("vec%0d.icache_addr", i), bus.icache_addr, tbl[i].e_addr);
                if (tbl[i].e_enq) begin
                    check($sformatf("vec%0d.iq_pc", i), bus.iq_pc, tbl[i].e_pc);
                    check($sformatf("vec%0d.iq_instr", i), bus.iq_instr, tbl[i].e_instr);
                end
            end
        end

        m_busy = 1'b0; m_kill = 1'b0; m_pc = RST_PC; m_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r    = (c == 0) || ($urandom_range(0, 99) == 0);
            fv   = ($urandom_range(0, 7) == 0);
            fpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC | $urandom_range(0, 3) : $urandom;
            full = ($urandom_range(0, 3) == 0);
            resp = ($urandom_range(0, 2) == 0);
            rd   = $urandom;
            drive(r, fv, fpc, full, resp, rd);

            x_read = m_busy && !r;
            x_enq  = m_busy && !m_kill && resp && !fv && !r;
            if (c != 0) begin
                check("rand.icache_read", {31'b0, bus.icache_read}, {31'b0, x_read});
                check("rand.iq_enq", {31'b0, bus.iq_enq}, {31'b0, x_enq});
                if (x_read) check("rand.icache_addr", bus.icache_addr, m_addr);
                if (x_enq) begin
                    check("rand.iq_pc", bus.iq_pc, m_addr);
                    check("rand.iq_instr", bus.iq_instr, rd);
                end
            end

            if (r) begin
                m_busy = 1'b0; m_kill = 1'b0; m_pc = RST_PC; m_addr = 32'h0;
            end else if (!m_busy) begin
                if (fv) m_pc = {fpc[31:2], 2'b00};
                else if (!full) begin
                    m_busy = 1'b1; m_addr = m_pc;
                end
            end else begin
                if (fv) m_pc = {fpc[31:2], 2'b00};
                if (resp) begin
                    if (!m_kill && !fv) m_pc = m_addr + 32'd4;
                    m_busy = 1'b0;
                    m_kill = 1'b0;
                end else if (fv) begin
                    m_kill = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
